bcd_ex3_seq: RTL and testbench

Sequential controller that converts a multi-digit packed BCD word to packed Excess-3. It processes one digit per clock through a single shared 4-bit digit converter, least-significant digit first. The block sits between a BCD producer and an Excess-3 consumer and uses valid/ready handshakes on both sides. It optionally flags non-BCD digit codes.

---
 rtl/bcd_ex3_seq.sv | 143 ++++++++++++++
 tb/tb_bcd_ex3_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_ex3_seq.sv
// bcd_ex3_seq: sequential packed-BCD to packed-Excess-3 converter.
// One digit per clock through a single shared 4-bit converter, least
// significant digit first, with valid/ready handshakes on both sides.
// Optional feature macro: BCD_EX3_ERRCHK_EN enables the invalid-digit flag
// on out_err; when undefined, out_err is tied low and no flag register exists.
module bcd_ex3_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_ex3,
  output logic                out_err,
  output logic                busy
);

  // A single digit still needs a 1-bit index so the register exists.
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] word_q, word_d;
  logic [4*DIGITS-1:0] ex3_q, ex3_d;
  logic [3:0]          digit;
  logic [3:0]          digitEx3;

`ifdef BCD_EX3_ERRCHK_EN
  logic                err_q, err_d;
`endif

  // Select the digit at the current index from the captured word.
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        digit = word_q[4*i +: 4];
      end
    end
  end

  // Shared converter: add 3 with 4-bit wraparound, covering all 16 codes.
  always_comb begin
    digitEx3 = digit + 4'd3;
  end

  // Next-state and handshake outputs; all control outputs derive from state only.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    ex3_d     = ex3_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
`ifdef BCD_EX3_ERRCHK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_bcd;
          idx_d   = '0;
`ifdef BCD_EX3_ERRCHK_EN
          err_d   = 1'b0;
`endif
          state_d = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDXW'(i)) begin
            ex3_d[4*i +: 4] = digitEx3;
          end
        end
`ifdef BCD_EX3_ERRCHK_EN
        err_d = err_q | (digit > 4'd9);
`endif
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, index, word and result registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      ex3_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      ex3_q   <= ex3_d;
    end
  end

`ifdef BCD_EX3_ERRCHK_EN
  // Sticky invalid-digit flag for the word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  assign out_ex3 = ex3_q;

endmodule

// File: tb/tb_bcd_ex3_seq.sv
// tb_bcd_ex3_seq: directed bench for bcd_ex3_seq with DIGITS=4.
// Expected out_err follows BCD_EX3_ERRCHK_EN the same way the design does.
module tb_bcd_ex3_seq;

`ifdef BCD_EX3_ERRCHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ex3;
  logic        out_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cycles;
  int cycleCount = 0;
  int acceptCycle;
  int prevAccept;

  logic [15:0] b2bIn  [3] = '{16'h0001, 16'h9999, 16'h4321};
  logic [15:0] b2bExp [3] = '{16'h3334, 16'hCCCC, 16'h7654};

  bcd_ex3_seq #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ex3   (out_ex3),
    .out_err   (out_err),
    .busy      (busy)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure accept spacing.
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
  end

  // Hard stop in case something unforeseen stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitOutValid();
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // Push one word with out_ready high and check latency, result and release.
  task automatic applyStimulus(input string tag, input logic [15:0] bcd,
                               input logic [15:0] expEx3, input logic expErr);
    in_valid  = 1'b1;
    in_bcd    = bcd;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_accept"}, {62'd0, in_ready, busy}, 64'b01);
    in_valid = 1'b0;
    waitOutValid();
    checkOutput({tag, "_latency"}, 64'(cycles), 64'd4);
    checkOutput({tag, "_ex3"}, {48'd0, out_ex3}, {48'd0, expEx3});
    checkOutput({tag, "_err"}, {63'd0, out_err}, {63'd0, expErr});
    @(posedge clk); #1;
    checkOutput({tag, "_release"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = 16'h0000;
    out_ready = 1'b0;
    #12;
    checkOutput("reset_state", {59'd0, in_ready, out_valid, out_err, busy, 1'b0},
                {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    checkOutput("reset_ex3", {48'd0, out_ex3}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus("basic",    16'h1234, 16'h4567, 1'b0);
    applyStimulus("boundary", 16'h9870, 16'hCBA3, 1'b0);
    applyStimulus("zeros",    16'h0000, 16'h3333, 1'b0);
    applyStimulus("highcode", 16'hF0D9, 16'h230C, ERR_EN);

    // Backpressure: result held while out_ready low, new words refused.
    in_valid  = 1'b1;
    in_bcd    = 16'h12A4;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitOutValid();
    checkOutput("bp_latency", 64'(cycles), 64'd4);
    checkOutput("bp_ex3", {48'd0, out_ex3}, 64'h45D7);
    checkOutput("bp_err", {63'd0, out_err}, {63'd0, ERR_EN});
    in_valid = 1'b1;
    in_bcd   = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold", {45'd0, out_valid, in_ready, out_err, out_ex3},
                  {45'd0, 1'b1, 1'b0, ERR_EN, 16'h45D7});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release", {62'd0, out_valid, in_ready}, 64'b01);

    // Reset two cycles into conversion.
    in_valid = 1'b1;
    in_bcd   = 16'h1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_ctrl", {61'd0, out_valid, busy, in_ready}, 64'b001);
    checkOutput("midreset_ex3", {48'd0, out_ex3}, 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus("after_reset", 16'h5555, 16'h8888, 1'b0);

    // Back-to-back stream with in_valid held high.
    prevAccept = 0;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_bcd     = b2bIn[0];
    for (int i = 0; i < 3; i++) begin
      cycles = 0;
      while (!busy && cycles < 20) begin
        @(posedge clk); #1;
        cycles++;
      end
      acceptCycle = cycleCount;
      if (i > 0) begin
        checkOutput("b2b_spacing", 64'(acceptCycle - prevAccept), 64'd6);
      end
      prevAccept = acceptCycle;
      if (i < 2) begin
        in_bcd = b2bIn[i+1];
      end else begin
        in_valid = 1'b0;
      end
      waitOutValid();
      checkOutput("b2b_latency", 64'(cycles), 64'd4);
      checkOutput("b2b_ex3", {48'd0, out_ex3}, {48'd0, b2bExp[i]});
      @(posedge clk); #1;
      checkOutput("b2b_release", {62'd0, out_valid, in_ready}, 64'b01);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
